riscv_mem_arbiter: RTL
======================

# riscv_mem_arbiter

Two-to-one memory port arbiter sharing a single memory request/response port between the core's instruction-memory and data-memory interfaces. It sits between `riscv_Core` and a single-ported test memory, forwarding requests with val/rdy handshakes and steering each in-order response back to the requester that issued it. The block tracks issuing order in an internal tag FIFO so responses need no ID field.

## Interface

Parameters:
- `p_req_sz`, 67, request message width; matches `VC_MEM_REQ_MSG_SZ(32,32)`.
- `p_resp_sz`, 35, response message width; matches `VC_MEM_RESP_MSG_SZ(32)`.
- `p_depth`, 4, maximum outstanding requests and tag FIFO depth; legal range is 1–15.

Ports (all signals are synchronous to `clk`; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `imemreq_msg`  in  p_req_sz  instruction request.
- `imemreq_val`  in  1  instruction request valid.
- `imemreq_rdy`  out  1  instruction request accepted.
- `imemresp_msg`  out  p_resp_sz  instruction response.
- `imemresp_val`  out  1  instruction response valid.
- `dmemreq_msg`  in  p_req_sz  data request.
- `dmemreq_val`  in  1  data request valid.
- `dmemreq_rdy`  out  1  data request accepted.
- `dmemresp_msg`  out  p_resp_sz  data response.
- `dmemresp_val`  out  1  data response valid.
- `memreq_msg`  out  p_req_sz  shared memory request.
- `memreq_val`  out  1  shared memory request valid.
- `memreq_rdy`  in  1  memory ready.
- `memresp_msg`  in  p_resp_sz  memory response.
- `memresp_val`  in  1  memory response valid. There is no response backpressure.
- `outstanding`  out  4  count of in-flight requests.
- `resp_err`  out  1  sticky flag: a response arrived with no outstanding request.

## Operation

- **Grant (combinational):**
  - With only one requester valid, that requester is granted.
  - With both valid, the round-robin pointer decides. `last_grant`=D grants I; `last_grant`=I grants D.
- **Request path:**
  - `memreq_msg` is the granted requester's message.
  - `memreq_val` = (any requester valid) & ~full.
  - The granted requester's `*_rdy` = `memreq_rdy` & ~full. The non-granted requester's `rdy` is 0.
- **Transfer:** a transfer occurs when `memreq_val` & `memreq_rdy`. On a transfer:
  - push the tag (0 = I, 1 = D) into the FIFO;
  - set `last_grant` to the granted requester.
- **Response path:**
  - `memresp_val` with the FIFO non-empty pops the head tag. The response is routed to I or D per the tag.
  - `memresp_msg` is copied unchanged to both `*resp_msg` outputs. Only the selected `*resp_val` is asserted.
- **Error case:** `memresp_val` with the FIFO empty:
  - both `*resp_val` stay 0;
  - nothing is popped;
  - `resp_err` sets and holds until reset.
- **Full:** full = (count == `p_depth`). When full, no request is accepted, even if a pop occurs in the same cycle.
- **Simultaneous push and pop when not full:** count is unchanged, and the FIFO pointers both advance and wrap modulo `p_depth`.
- **Counter:** `outstanding` = count. It is +1 on a push, −1 on a valid pop, and never exceeds `p_depth` or drops below 0.

## Timing

- The request path has zero added latency: requests are combinational pass-through in the cycle of grant.
- The response path has zero added latency: routing is combinational from the FIFO head.
- A response to a request cannot be routed in the same cycle as that request's push. The memory must respond at least 1 cycle later; an earlier response is treated as an empty-FIFO error.
- Reset values, while `reset` is low, are all forced regardless of inputs:
  - `memreq_val`, `imemreq_rdy`, `dmemreq_rdy`, `imemresp_val`, `dmemresp_val` = 0;
  - `outstanding` = 0;
  - `resp_err` = 0;
  - FIFO pointers = 0;
  - `last_grant` = D, so I wins the first tie.
- **Reset mid-operation:** all in-flight tags are discarded. Responses arriving after reset deasserts set `resp_err`.
- State updates occur on the `clk` rising edge only.

## Configuration

- `RISCV_MEM_ARBITER_DMEM_PRIO_EN`:
  - **Defined:** fixed priority. D wins every tie, and `last_grant` is ignored; I is served only when D is not valid.
  - **Undefined:** round-robin as described above.

## Test plan

- **Tie-break after reset:** I and D both valid continuously, `memreq_rdy`=1, memory responds 1 cycle later. Grants alternate I, D, I, D. Each response goes to the tagged requester: data 0x11 → imem, 0x22 → dmem. `outstanding` peaks at 1.
- **Full FIFO:** `p_depth`=4, `memreq_rdy`=1, no responses, I valid for 6 cycles. Exactly 4 transfers occur, then `imemreq_rdy`=0 and `outstanding`=4. One `memresp_val` pulse drops `outstanding` to 3; `rdy` returns the next cycle.
- **Memory backpressure:** `memreq_rdy`=0 with D valid. `dmemreq_rdy`=0, nothing is pushed, and `last_grant` is unchanged.
- **Spurious response:** `memresp_val` with the FIFO empty. Both `*resp_val` stay 0, `resp_err`=1 and stays 1 until `reset` goes low.
- **Reset mid-operation:** assert `reset` low with 3 outstanding. `outstanding`=0 immediately (asynchronous) and all outputs are at reset values. A subsequent response sets `resp_err`.
- **`RISCV_MEM_ARBITER_DMEM_PRIO_EN` defined:** I and D both valid for 4 cycles. D is granted all 4 cycles and I receives 0 grants.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Two-to-one val/rdy memory arbiter with an in-order tag FIFO for response steering.
// Optional build macro RISCV_MEM_ARBITER_DMEM_PRIO_EN: D wins every tie (fixed priority).
module riscv_mem_arbiter #(
  parameter int unsigned p_req_sz  = 67,
  parameter int unsigned p_resp_sz = 35,
  parameter int unsigned p_depth   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [p_req_sz-1:0]  imemreq_msg,
  input  logic                 imemreq_val,
  output logic                 imemreq_rdy,
  output logic [p_resp_sz-1:0] imemresp_msg,
  output logic                 imemresp_val,
  input  logic [p_req_sz-1:0]  dmemreq_msg,
  input  logic                 dmemreq_val,
  output logic                 dmemreq_rdy,
  output logic [p_resp_sz-1:0] dmemresp_msg,
  output logic                 dmemresp_val,
  output logic [p_req_sz-1:0]  memreq_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  input  logic [p_resp_sz-1:0] memresp_msg,
  input  logic                 memresp_val,
  output logic [3:0]           outstanding,
  output logic                 resp_err
);

  localparam int unsigned   AW    = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [3:0]    DEPTH = 4'(p_depth);
  localparam logic [AW-1:0] LAST  = AW'(p_depth - 1);

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  req_e               last_grant_q, last_grant_d;
  req_e               gnt;
  logic [p_depth-1:0] tag_q, tag_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [3:0]         count_q, count_d;
  logic               resp_err_q, resp_err_d;

  logic full, empty, accept, push, pop, head_tag;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    gnt = REQ_I;
    if (dmemreq_val && !imemreq_val) begin
      gnt = REQ_D;
    end else if (dmemreq_val && imemreq_val) begin
`ifdef RISCV_MEM_ARBITER_DMEM_PRIO_EN
      gnt = REQ_D;
`else
      gnt = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
`endif
    end
  end

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign head_tag = tag_q[rd_ptr_q];

  // Every handshake output is gated by reset so it reads idle while reset is held low.
  assign accept      = reset & memreq_rdy & ~full;
  assign memreq_val  = reset & (imemreq_val | dmemreq_val) & ~full;
  assign memreq_msg  = (gnt == REQ_D) ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = accept & imemreq_val & (gnt == REQ_I);
  assign dmemreq_rdy = accept & dmemreq_val & (gnt == REQ_D);

  assign push = memreq_val & memreq_rdy;
  assign pop  = reset & memresp_val & ~empty;

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = pop & ~head_tag;
  assign dmemresp_val = pop & head_tag;

  assign outstanding = count_q;
  assign resp_err    = resp_err_q;

  always_comb begin
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    resp_err_d   = resp_err_q | (memresp_val & empty);

    if (push) begin
      tag_d[wr_ptr_q] = (gnt == REQ_D);
      wr_ptr_d        = bump(wr_ptr_q);
      last_grant_d    = gnt;
    end
    if (pop) begin
      rd_ptr_d = bump(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= REQ_D;
      resp_err_q   <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
